// File: rtl/network_config_pkg.sv
// Network-wide shape constants shared by the stream source and sink.
// NET_NUM_OUT: number of output neurons (fire bits per tick).
package network_config;

  localparam int NET_NUM_OUT = 4;

endpackage

// File: rtl/sink_config_pkg.sv
// Sink-side word format: opcode type, opcode width, width helper.
// Words are {opcode, payload} with the opcode in the MSBs.
package sink_config;

  import network_config::*;

  localparam int OPC_WIDTH = 1;

  typedef enum logic [OPC_WIDTH-1:0] {
    SPK = 1'b0,
    RUN = 1'b1
  } opcode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sink_fifo.sv
// Dual-write / single-read FIFO for the sink word stream.
// Ports: wr_en[1:0] (slot 0 lands first), wr_data0/1, rd_en, rd_data,
// empty, free_cnt. Pointers wrap modulo DEPTH (power of two).
module sink_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [1:0]       wr_en,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    free_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr_b;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    n_wr;
  logic             do_rd;

  assign empty    = (cnt == '0);
  assign free_cnt = CW'(DEPTH) - cnt;
  assign do_rd    = rd_en && !empty;
  assign n_wr     = CW'(wr_en[0]) + CW'(wr_en[1]);
  // slot 1 follows slot 0 only when slot 0 is actually written
  assign wptr_b   = wptr + AW'(wr_en[0]);
  assign rd_data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[wptr]   <= wr_data0;
    if (wr_en[1]) mem[wptr_b] <= wr_data1;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + AW'(n_wr);
      if (do_rd) rptr <= rptr + AW'(1);
      cnt  <= cnt + n_wr - CW'(do_rd);
    end
  end

endmodule

// File: rtl/network_sink.sv
// Network output sink: captures one spike vector per tick, buffers and
// emits {opcode, payload} words toward the host packer.
// Ports: clk, arstn (async, active-low); net_valid/net_ready/net_out
// tick input; flush (emit pending zero run); snk_valid/snk_ready/snk.
// Build option: define SINK_RLE_EN to run-length encode zero ticks
// into RUN words; otherwise every tick becomes an SPK word.
module network_sink
  import network_config::*;
  import sink_config::*;
#(
  parameter int RUN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PAYLOAD_WIDTH = max_int(NET_NUM_OUT, RUN_WIDTH),
  localparam int SNK_WIDTH     = OPC_WIDTH + PAYLOAD_WIDTH
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   net_valid,
  output logic                   net_ready,
  input  logic [NET_NUM_OUT-1:0] net_out,
  input  logic                   flush,
  output logic                   snk_valid,
  input  logic                   snk_ready,
  output logic [SNK_WIDTH-1:0]   snk
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           wr_en;
  logic [SNK_WIDTH-1:0] wr_data0;
  logic [SNK_WIDTH-1:0] wr_data1;
  logic [SNK_WIDTH-1:0] rd_data;
  logic                 empty;
  logic [CW-1:0]        free_cnt;
  logic                 accept;

  function automatic logic [SNK_WIDTH-1:0] spk_word(
    input logic [NET_NUM_OUT-1:0] v
  );
    logic [PAYLOAD_WIDTH-1:0] p;
    p = '0;
    p[NET_NUM_OUT-1:0] = v;
    return {SPK, p};
  endfunction

  assign accept = net_valid && net_ready;

`ifdef SINK_RLE_EN

  localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

  function automatic logic [SNK_WIDTH-1:0] run_word(
    input logic [RUN_WIDTH-1:0] n
  );
    logic [PAYLOAD_WIDTH-1:0] p;
    p = '0;
    p[RUN_WIDTH-1:0] = n;
    return {RUN, p};
  endfunction

  logic [RUN_WIDTH-1:0] run_q;
  logic [RUN_WIDTH-1:0] run_d;
  logic [RUN_WIDTH-1:0] run_inc;
  logic                 pend_q;
  logic                 pend_d;
  logic                 pend_eff;
  logic                 acc_zero;
  logic                 acc_nz;
  logic                 flush_go;

  // two free slots so a RUN+SPK pair always fits
  assign net_ready = (free_cnt >= CW'(2));
  assign run_inc   = run_q + RUN_WIDTH'(1);
  // a flush in this cycle counts as pending already
  assign pend_eff  = pend_q || flush;
  assign acc_zero  = accept && (net_out == '0);
  assign acc_nz    = accept && (net_out != '0);
  assign flush_go  = !accept && pend_eff && (free_cnt != '0);

  always_comb begin
    wr_en    = 2'b00;
    wr_data0 = '0;
    wr_data1 = '0;
    run_d    = run_q;
    pend_d   = pend_eff;
    unique case (1'b1)
      acc_zero: begin
        run_d = run_inc;
        if (run_inc == RUN_MAX) begin
          wr_en    = 2'b01;
          wr_data0 = run_word(RUN_MAX);
          run_d    = '0;
        end
      end
      acc_nz: begin
        run_d  = '0;
        pend_d = 1'b0;
        if (run_q != '0) begin
          wr_en    = 2'b11;
          wr_data0 = run_word(run_q);
          wr_data1 = spk_word(net_out);
        end else begin
          wr_en    = 2'b01;
          wr_data0 = spk_word(net_out);
        end
      end
      flush_go: begin
        run_d  = '0;
        pend_d = 1'b0;
        if (run_q != '0) begin
          wr_en    = 2'b01;
          wr_data0 = run_word(run_q);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      run_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
    end
  end

`else

  logic unused_flush;

  assign unused_flush = flush;
  assign net_ready    = (free_cnt != '0);
  assign wr_en        = {1'b0, accept};
  assign wr_data0     = spk_word(net_out);
  assign wr_data1     = '0;

`endif

  sink_fifo #(
    .WIDTH(SNK_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .wr_en   (wr_en),
    .wr_data0(wr_data0),
    .wr_data1(wr_data1),
    .rd_en   (snk_ready),
    .rd_data (rd_data),
    .empty   (empty),
    .free_cnt(free_cnt)
  );

  assign snk_valid = !empty;
  assign snk       = empty ? '0 : rd_data;

endmodule

// File: tb/tb_network_sink.sv
// Randomized bench for network_sink with a queue-based word model.
// Works with or without SINK_RLE_EN defined.
module tb_network_sink;

  localparam int NO    = 4;
  localparam int RW    = 2;
  localparam int DEPTH = 4;
  localparam int RMAX  = 3;
`ifdef SINK_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          net_valid = 1'b0;
  logic          net_ready;
  logic [NO-1:0] net_out = '0;
  logic          flush = 1'b0;
  logic          snk_valid;
  logic          snk_ready = 1'b0;
  logic [4:0]    snk;

  network_sink #(
    .RUN_WIDTH (RW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .net_valid(net_valid),
    .net_ready(net_ready),
    .net_out  (net_out),
    .flush    (flush),
    .snk_valid(snk_valid),
    .snk_ready(snk_ready),
    .snk      (snk)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] q[$];
  logic [3:0] tq[$];
  int         rc = 0;
  bit         pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] spk_w(input logic [3:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [4:0] run_w(input int n);
    return {1'b1, 4'(n)};
  endfunction

  task automatic cyc(input bit fl, input bit sr);
    int         fr;
    bit         mr;
    bit         acc;
    bit         pop;
    logic [3:0] d;
    logic [4:0] pw[$];
    fr = DEPTH - q.size();
    mr = RLE ? (fr >= 2) : (fr >= 1);
    chk("snk_valid", snk_valid, q.size() != 0);
    if (q.size() != 0) chk("snk", snk, q[0]);
    chk("net_ready", net_ready, mr);
    d = (tq.size() > 0) ? tq[0] : 4'h0;
    net_valid = tq.size() > 0;
    net_out   = d;
    flush     = fl;
    snk_ready = sr;
    acc = net_valid && mr;
    pop = (q.size() > 0) && sr;
    if (RLE) begin
      pend = pend || fl;
      if (acc && d == 4'h0) begin
        rc++;
        if (rc == RMAX) begin
          pw.push_back(run_w(RMAX));
          rc = 0;
        end
      end else if (acc) begin
        if (rc > 0) pw.push_back(run_w(rc));
        pw.push_back(spk_w(d));
        rc = 0;
        pend = 1'b0;
      end else if (pend && fr >= 1) begin
        if (rc > 0) pw.push_back(run_w(rc));
        rc = 0;
        pend = 1'b0;
      end
    end else if (acc) begin
      pw.push_back(spk_w(d));
    end
    if (acc) void'(tq.pop_front());
    if (pop) void'(q.pop_front());
    foreach (pw[i]) q.push_back(pw[i]);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    arstn     = 1'b0;
    net_valid = 1'b0;
    flush     = 1'b0;
    #1;
    chk("rst_snk_valid", snk_valid, 1'b0);
    chk("rst_snk", snk, 5'h0);
    q.delete();
    tq.delete();
    rc   = 0;
    pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    tq.push_back(4'b0101);
    tq.push_back(4'b1000);
    repeat (6) cyc(1'b0, 1'b1);

    for (int i = 0; i < 6; i++) tq.push_back(4'(i + 1));
    repeat (10) cyc(1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b1);

    repeat (3) tq.push_back(4'h0);
    tq.push_back(4'b0010);
    repeat (8) cyc(1'b0, 1'b1);

    repeat (7) tq.push_back(4'h0);
    repeat (10) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);

    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);

    tq.push_back(4'h3);
    tq.push_back(4'h0);
    tq.push_back(4'h0);
    tq.push_back(4'h6);
    tq.push_back(4'h0);
    repeat (8) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1);

    tq.push_back(4'h1);
    tq.push_back(4'h0);
    tq.push_back(4'h0);
    tq.push_back(4'h2);
    tq.push_back(4'h0);
    repeat (8) cyc(1'b0, 1'b0);
    do_reset();
    repeat (3) tq.push_back(4'h0);
    tq.push_back(4'h9);
    repeat (8) cyc(1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if (tq.size() == 0)
        tq.push_back(($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom));
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    repeat (12) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (12) cyc(1'b0, 1'b1);
    chk("drained", snk_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
